cci_mpf_svc_vtp_tlb_nport: RTL

- Parametrised N-port, set-associative TLB for the VTP shim.
- Successor to the fixed two-port TLB lookup/fill server. Adds configurable port count, sets and ways, per-set round-robin replacement, in-place update on refill, and a full-invalidate sweep.
- Each port has a fixed two-cycle lookup pipeline that reports either a hit with the physical page index, or a miss with the missing VA page.
- A single fill port and a single invalidate request share one write path.

---
 rtl/cci_mpf_svc_vtp_tlb_nport_if.sv | 32 +++
 rtl/cci_mpf_svc_vtp_tlb_nport.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cci_mpf_svc_vtp_tlb_nport_if.sv
// Lookup, fill and invalidate signal bundle between the VTP TLB and its clients.
interface cci_mpf_svc_vtp_tlb_nport_if #(
  parameter int unsigned N_LOOKUP_PORTS = 2,
  parameter int unsigned VA_PAGE_BITS   = 36,
  parameter int unsigned PA_IDX_BITS    = 20
);
  logic [N_LOOKUP_PORTS-1:0]              lookupEn;
  logic [N_LOOKUP_PORTS*VA_PAGE_BITS-1:0] lookupPageVA;
  logic                                   lookupRdy;
  logic [N_LOOKUP_PORTS-1:0]              lookupValid;
  logic [N_LOOKUP_PORTS*PA_IDX_BITS-1:0]  lookupRspPagePA;
  logic [N_LOOKUP_PORTS-1:0]              lookupMiss;
  logic [N_LOOKUP_PORTS*VA_PAGE_BITS-1:0] lookupMissVA;
  logic                                   fillEn;
  logic [VA_PAGE_BITS-1:0]                fillVA;
  logic [PA_IDX_BITS-1:0]                 fillPA;
  logic                                   fillRdy;
  logic                                   invalAllReq;
  logic                                   invalAllDone;

  modport slave (
    input  lookupEn, lookupPageVA, fillEn, fillVA, fillPA, invalAllReq,
    output lookupRdy, lookupValid, lookupRspPagePA, lookupMiss, lookupMissVA,
           fillRdy, invalAllDone
  );

  modport master (
    output lookupEn, lookupPageVA, fillEn, fillVA, fillPA, invalAllReq,
    input  lookupRdy, lookupValid, lookupRspPagePA, lookupMiss, lookupMissVA,
           fillRdy, invalAllDone
  );
endinterface

// File: rtl/cci_mpf_svc_vtp_tlb_nport.sv
// N-port set-associative VTP TLB: fixed 2-cycle lookups, single fill/invalidate
// write path, per-set round-robin replacement.
module cci_mpf_svc_vtp_tlb_nport #(
  parameter int unsigned N_LOOKUP_PORTS = 2,
  parameter int unsigned NUM_SETS       = 64,
  parameter int unsigned NUM_WAYS       = 4,
  parameter int unsigned VA_PAGE_BITS   = 36,
  parameter int unsigned PA_IDX_BITS    = 20
) (
  input  logic                              clk,
  input  logic                              reset,
  cci_mpf_svc_vtp_tlb_nport_if.slave        tlb
);
  localparam int unsigned N     = N_LOOKUP_PORTS;
  localparam int unsigned SET_W = $clog2(NUM_SETS);
  localparam int unsigned WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned TAG_W = VA_PAGE_BITS - SET_W;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_FILL_RD, ST_FILL_WR, ST_INVAL
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [SET_W-1:0]   r_set_cnt, w_set_cnt_nxt;
  logic               r_rdy, w_rdy_nxt;
  logic               r_inval_done, w_inval_done_nxt;
  logic               w_clr_en, w_fill_acc, w_fill_wr;

  logic [NUM_WAYS-1:0]    r_valid  [NUM_SETS];
  logic [WAY_W-1:0]       r_victim [NUM_SETS];
  logic [TAG_W-1:0]       r_tag    [NUM_SETS][NUM_WAYS];
  logic [PA_IDX_BITS-1:0] r_pa     [NUM_SETS][NUM_WAYS];

  // Control FSM next-state and write-path strobes
  always_comb begin
    w_state_nxt      = r_state;
    w_set_cnt_nxt    = r_set_cnt;
    w_inval_done_nxt = 1'b0;
    w_clr_en         = 1'b0;
    w_fill_acc       = 1'b0;
    w_fill_wr        = 1'b0;
    case (r_state)
      ST_INIT, ST_INVAL: begin
        w_clr_en      = 1'b1;
        w_set_cnt_nxt = r_set_cnt + SET_W'(1);
        if (r_set_cnt == SET_W'(NUM_SETS - 1)) begin
          w_state_nxt      = ST_IDLE;
          w_inval_done_nxt = (r_state == ST_INVAL);
        end
      end
      ST_IDLE: begin
        if (tlb.fillEn) begin
          w_fill_acc  = 1'b1;
          w_state_nxt = ST_FILL_RD;
        end else if (tlb.invalAllReq && !r_inval_done) begin
          // Request is still high while the done pulse is out; don't restart
          w_state_nxt   = ST_INVAL;
          w_set_cnt_nxt = '0;
        end
      end
      ST_FILL_RD: w_state_nxt = ST_FILL_WR;
      ST_FILL_WR: begin
        w_fill_wr   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_INIT;
    endcase
    w_rdy_nxt = (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_set_cnt    <= '0;
      r_rdy        <= 1'b0;
      r_inval_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_set_cnt    <= w_set_cnt_nxt;
      r_rdy        <= w_rdy_nxt;
      r_inval_done <= w_inval_done_nxt;
    end
  end

  // Fill request capture and way selection
  logic [TAG_W-1:0]       r_fill_tag;
  logic [SET_W-1:0]       r_fill_set;
  logic [PA_IDX_BITS-1:0] r_fill_pa;
  logic                   r_fill_hit, r_fill_has_inv;
  logic [WAY_W-1:0]       r_fill_hit_way, r_fill_inv_way;
  logic                   w_fhit, w_finv;
  logic [WAY_W-1:0]       w_fhit_way, w_finv_way, w_wr_way, w_victim_nxt;

  // Descending scan leaves the lowest-index invalid way selected
  always_comb begin
    w_fhit     = 1'b0;
    w_fhit_way = '0;
    w_finv     = 1'b0;
    w_finv_way = '0;
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (r_valid[r_fill_set][w] && (r_tag[r_fill_set][w] == r_fill_tag)) begin
        w_fhit     = 1'b1;
        w_fhit_way = WAY_W'(w);
      end
      if (!r_valid[r_fill_set][w]) begin
        w_finv     = 1'b1;
        w_finv_way = WAY_W'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_acc) begin
      r_fill_tag <= tlb.fillVA[VA_PAGE_BITS-1:SET_W];
      r_fill_set <= tlb.fillVA[SET_W-1:0];
      r_fill_pa  <= tlb.fillPA;
    end
    if (r_state == ST_FILL_RD) begin
      r_fill_hit     <= w_fhit;
      r_fill_hit_way <= w_fhit_way;
      r_fill_has_inv <= w_finv;
      r_fill_inv_way <= w_finv_way;
    end
  end

  always_comb begin
    w_victim_nxt = (r_victim[r_fill_set] == WAY_W'(NUM_WAYS - 1)) ?
                   '0 : r_victim[r_fill_set] + WAY_W'(1);
    if (r_fill_hit)          w_wr_way = r_fill_hit_way;
    else if (r_fill_has_inv) w_wr_way = r_fill_inv_way;
    else                     w_wr_way = r_victim[r_fill_set];
  end

  // Tag/PA array write port shared by init, invalidate and fill
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_clr_en) begin
        r_valid[r_set_cnt]  <= '0;
        r_victim[r_set_cnt] <= '0;
      end
      if (w_fill_wr) begin
        r_valid[r_fill_set][w_wr_way] <= 1'b1;
        r_tag[r_fill_set][w_wr_way]   <= r_fill_tag;
        r_pa[r_fill_set][w_wr_way]    <= r_fill_pa;
        if (!r_fill_hit && !r_fill_has_inv) r_victim[r_fill_set] <= w_victim_nxt;
      end
    end
  end

  // Lookup pipeline: stage 1 holds the accepted VA, array read + compare feed outputs
  logic [N-1:0]            r_s1_en;
  logic [VA_PAGE_BITS-1:0] r_s1_va [N];
  logic [SET_W-1:0]        w_lk_set [N];
  logic [TAG_W-1:0]        w_lk_tag [N];
  logic [N-1:0]            w_hit;
  logic [PA_IDX_BITS-1:0]  w_hit_pa [N];

  always_ff @(posedge clk) begin
    if (reset) r_s1_en <= '0;
    else       r_s1_en <= tlb.lookupEn & {N{r_rdy}};
    for (int i = 0; i < int'(N); i++) begin
      if (tlb.lookupEn[i]) r_s1_va[i] <= tlb.lookupPageVA[i*VA_PAGE_BITS +: VA_PAGE_BITS];
    end
  end

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_hit_pa[i] = '0;
      w_lk_set[i] = r_s1_va[i][SET_W-1:0];
      w_lk_tag[i] = r_s1_va[i][VA_PAGE_BITS-1:SET_W];
      for (int w = 0; w < int'(NUM_WAYS); w++) begin
        if (r_valid[w_lk_set[i]][w] && (r_tag[w_lk_set[i]][w] == w_lk_tag[i])) begin
          w_hit[i]    = 1'b1;
          w_hit_pa[i] = r_pa[w_lk_set[i]][w];
        end
      end
    end
  end

  logic [N-1:0]                r_lk_valid, r_lk_miss;
  logic [N*PA_IDX_BITS-1:0]    r_rsp_pa;
  logic [N*VA_PAGE_BITS-1:0]   r_miss_va;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lk_valid <= '0;
      r_lk_miss  <= '0;
      r_rsp_pa   <= '0;
      r_miss_va  <= '0;
    end else begin
      r_lk_valid <= r_s1_en & w_hit;
      r_lk_miss  <= r_s1_en & ~w_hit;
      for (int i = 0; i < int'(N); i++) begin
        if (r_s1_en[i]) begin
          r_rsp_pa[i*PA_IDX_BITS +: PA_IDX_BITS]    <= w_hit_pa[i];
          r_miss_va[i*VA_PAGE_BITS +: VA_PAGE_BITS] <= r_s1_va[i];
        end
      end
    end
  end

  assign tlb.lookupRdy       = r_rdy;
  assign tlb.fillRdy         = r_rdy;
  assign tlb.invalAllDone    = r_inval_done;
  assign tlb.lookupValid     = r_lk_valid;
  assign tlb.lookupMiss      = r_lk_miss;
  assign tlb.lookupRspPagePA = r_rsp_pa;
  assign tlb.lookupMissVA    = r_miss_va;

endmodule
